// File: rtl/hmac_req_arbiter.sv
// -----------------------------------------------------------------------------
// hmac_req_arbiter
//   Shares one HMAC engine between NUM_REQ requesters. Requests are served
//   round-robin: the search for the next owner starts at the index after the
//   last one served. The winner's key and message block are latched at grant
//   time and drive the engine until the operation finishes. Each engine-wait
//   phase is bounded by TIMEOUT cycles; an expired wait reports an error to
//   the owner and frees the engine.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  maximum cycles spent in each engine-wait state
//
// Ports
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   req_i             per-requester request, level-sensitive
//   key_i             per-requester 256-bit key, slice i = [256*i +: 256]
//   msg_i             per-requester 512-bit block, slice i = [512*i +: 512]
//   gnt_o             one-hot owner of the engine (or zero)
//   done_o            one-cycle completion pulse to the owner
//   err_o             one-cycle timeout pulse to the owner
//   hash_o            last captured digest
//   eng_init_o        engine start pulse
//   eng_key_o         latched key driven to the engine
//   eng_msg_o         latched message driven to the engine
//   eng_ready_i       engine idle/ready status
//   eng_hash_valid_i  engine digest valid
//   eng_hash_i        engine digest
// -----------------------------------------------------------------------------
module hmac_req_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*256-1:0] key_i,
  input  logic [NUM_REQ*512-1:0] msg_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic [255:0]           hash_o,
  output logic                   eng_init_o,
  output logic [255:0]           eng_key_o,
  output logic [511:0]           eng_msg_o,
  input  logic                   eng_ready_i,
  input  logic                   eng_hash_valid_i,
  input  logic [255:0]           eng_hash_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]         r_state;
  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [255:0]       r_hash;
  logic [255:0]       r_key;
  logic [511:0]       r_msg;

  logic               w_found;
  logic [IW-1:0]      w_sel;
  logic [NUM_REQ-1:0] w_gnt_sel;
  logic [IW-1:0]      w_rr_next;
  logic               w_busy_exit;
  logic               w_done_exit;
  logic               w_cnt_last;
  logic               w_timeout;

  // (base + off) mod NUM_REQ; both operands are below NUM_REQ, so a single
  // conditional subtraction is enough.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned   off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IW-1:0];
  endfunction

  // Round-robin search: first requesting index at or after r_rr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_i[wrap_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_rr, k);
      end
    end
  end

  assign w_gnt_sel = NUM_REQ'(1) << w_sel;
  assign w_rr_next = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  assign w_busy_exit = !eng_ready_i;
  assign w_done_exit = eng_ready_i && eng_hash_valid_i;
  assign w_cnt_last  = (r_cnt == CW'(TIMEOUT - 1));

  // Timeout fires only when the current wait state's exit condition is absent
  // in the cycle the counter reaches its last value.
  assign w_timeout = w_cnt_last &&
                     (((r_state == S_WAIT_BUSY) && !w_busy_exit) ||
                      ((r_state == S_WAIT_DONE) && !w_done_exit));

  // done/err are decoded from state while gnt is still held, so each pulse
  // lands on the owner and both are cleared by the same edge that drops gnt.
  assign gnt_o      = r_gnt;
  assign done_o     = (r_state == S_RESP) ? r_gnt : '0;
  assign err_o      = w_timeout ? r_gnt : '0;
  assign eng_init_o = (r_state == S_START);
  assign hash_o     = r_hash;
  assign eng_key_o  = r_key;
  assign eng_msg_o  = r_msg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_hash  <= '0;
      r_key   <= '0;
      r_msg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && eng_ready_i) begin
            r_idx   <= w_sel;
            r_gnt   <= w_gnt_sel;
            r_key   <= key_i[256*w_sel +: 256];
            r_msg   <= msg_i[512*w_sel +: 512];
            r_state <= S_START;
          end
        end

        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (w_busy_exit) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_rr    <= w_rr_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (w_done_exit) begin
            r_hash  <= eng_hash_i;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_rr    <= w_rr_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_gnt   <= '0;
          r_rr    <= w_rr_next;
          r_state <= S_IDLE;
        end

        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_req_arbiter.sv
module tb_hmac_req_arbiter;

  localparam int unsigned ENG_LAT  = 64;
  localparam int unsigned WAIT_MAX = 400;

  localparam logic [255:0] K0  = {8{32'h0123_4567}};
  localparam logic [255:0] K1  = {8{32'h89AB_CDEF}};
  localparam logic [255:0] K1N = {8{32'hFFFF_0000}};
  localparam logic [511:0] M0  = {16{32'h1111_0000}};
  localparam logic [511:0] M1  = {16{32'h2222_0001}};
  localparam logic [511:0] M1N = {16{32'h3333_3333}};
  localparam logic [255:0] H_A = {8{32'hA5A5_0000}};
  localparam logic [255:0] H_B = {8{32'hB0B0_0000}};
  localparam logic [255:0] H_C = {8{32'hC0C0_0000}};
  localparam logic [255:0] H_D = {8{32'hD0D0_0000}};
  localparam logic [255:0] H_X = {8{32'hDEAD_BEEF}};

  typedef struct {
    logic [1:0]   done;
    logic [1:0]   err;
    logic [1:0]   gnt;
    logic [255:0] hash;
    logic [255:0] key;
    logic [511:0] msg;
  } exp_t;

  exp_t sb[$];
  exp_t sb_to[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int init_cnt = 0;
  int to_init_cyc = 0;

  logic clk;
  logic rst_n;

  // main instance
  logic [1:0]    req;
  logic [511:0]  key;
  logic [1023:0] msg;
  logic [1:0]    gnt, done, err;
  logic [255:0]  hash, ekey;
  logic [511:0]  emsg;
  logic          init;
  logic          eng_ready, eng_valid;
  logic [255:0]  eng_hash;
  logic [255:0]  eng_next_hash;

  // short-timeout instance, engine never drops ready
  logic [1:0]    req_to;
  logic [1:0]    to_gnt, to_done, to_err;
  logic [255:0]  to_hash, to_key;
  logic [511:0]  to_msg;
  logic          to_init;
  logic          to_ready, to_valid;
  logic [255:0]  to_eng_hash;

  hmac_req_arbiter #(.NUM_REQ(2), .TIMEOUT(1024)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .key_i(key), .msg_i(msg),
    .gnt_o(gnt), .done_o(done), .err_o(err), .hash_o(hash),
    .eng_init_o(init), .eng_key_o(ekey), .eng_msg_o(emsg),
    .eng_ready_i(eng_ready), .eng_hash_valid_i(eng_valid), .eng_hash_i(eng_hash)
  );

  hmac_req_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) u_dut_to (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_to), .key_i(key), .msg_i(msg),
    .gnt_o(to_gnt), .done_o(to_done), .err_o(to_err), .hash_o(to_hash),
    .eng_init_o(to_init), .eng_key_o(to_key), .eng_msg_o(to_msg),
    .eng_ready_i(to_ready), .eng_hash_valid_i(to_valid), .eng_hash_i(to_eng_hash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [1:0] d, input logic [1:0] e, input logic [1:0] g,
                          input logic [255:0] h, input logic [255:0] k, input logic [511:0] m);
    exp_t x;
    x.done = d; x.err = e; x.gnt = g; x.hash = h; x.key = k; x.msg = m;
    sb.push_back(x);
  endtask

  task automatic push_to(input logic [1:0] e, input logic [1:0] g,
                         input logic [255:0] k, input logic [511:0] m);
    exp_t x;
    x.done = 2'b00; x.err = e; x.gnt = g; x.hash = '0; x.key = k; x.msg = m;
    sb_to.push_back(x);
  endtask

  // Engine model: goes busy one cycle after init, presents the digest
  // ENG_LAT cycles after init.
  initial begin
    eng_ready = 1'b1;
    eng_valid = 1'b0;
    eng_hash  = '0;
    forever begin
      @(negedge clk);
      eng_valid = 1'b0;
      if (init) begin
        @(negedge clk);
        eng_ready = 1'b0;
        repeat (ENG_LAT - 1) @(negedge clk);
        eng_hash      = eng_next_hash;
        eng_next_hash = eng_next_hash + 256'd1;
        eng_ready     = 1'b1;
        eng_valid     = 1'b1;
      end
    end
  end

  // Monitor for the main instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (init) init_cnt++;
      if ((done | err) != 2'b00) begin
        chk("done_err_excl", 512'(done & err), 512'(0));
        if (sb.size() == 0) begin
          chk("unexpected_resp", 512'({done, err}), 512'(0));
        end else begin
          e = sb.pop_front();
          chk("resp_done", 512'(done), 512'(e.done));
          chk("resp_err",  512'(err),  512'(e.err));
          chk("resp_gnt",  512'(gnt),  512'(e.gnt));
          chk("resp_hash", 512'(hash), 512'(e.hash));
          chk("resp_key",  512'(ekey), 512'(e.key));
          chk("resp_msg",  emsg,       e.msg);
        end
      end
    end
  end

  // Monitor for the short-timeout instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (to_init) to_init_cyc = cyc;
      if ((to_done | to_err) != 2'b00) begin
        if (sb_to.size() == 0) begin
          chk("to_unexpected", 512'({to_done, to_err}), 512'(0));
        end else begin
          e = sb_to.pop_front();
          chk("to_done", 512'(to_done), 512'(e.done));
          chk("to_err",  512'(to_err),  512'(e.err));
          chk("to_gnt",  512'(to_gnt),  512'(e.gnt));
          chk("to_hash", 512'(to_hash), 512'(e.hash));
          chk("to_key",  512'(to_key),  512'(e.key));
          chk("to_msg",  to_msg,        e.msg);
          chk("to_latency", 512'(cyc - to_init_cyc), 512'(16));
        end
      end
    end
  end

  task automatic wait_resp(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((done | err) == 2'b00) && (k < WAIT_MAX));
    chk(nm, 512'(|(done | err)), 512'(1));
  endtask

  task automatic wait_gnt(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((gnt == 2'b00) && (k < WAIT_MAX));
    chk(nm, 512'(|gnt), 512'(1));
  endtask

  task automatic wait_to(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((to_done | to_err) == 2'b00) && (k < WAIT_MAX));
    chk(nm, 512'(|(to_done | to_err)), 512'(1));
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_gnt"},  512'(gnt),  512'(0));
    chk({pfx, "_done"}, 512'(done), 512'(0));
    chk({pfx, "_err"},  512'(err),  512'(0));
    chk({pfx, "_init"}, 512'(init), 512'(0));
    chk({pfx, "_hash"}, 512'(hash), 512'(0));
    chk({pfx, "_key"},  512'(ekey), 512'(0));
    chk({pfx, "_msg"},  emsg,       512'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    req           = 2'b00;
    req_to        = 2'b00;
    key           = {K1, K0};
    msg           = {M1, M0};
    eng_next_hash = '0;
    to_ready      = 1'b1;
    to_valid      = 1'b1;
    to_eng_hash   = H_X;

    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single request, full engine handshake
    eng_next_hash = H_A;
    init_cnt = 0;
    push_exp(2'b01, 2'b00, 2'b01, H_A, K0, M0);
    req = 2'b01;
    wait_resp("a_resp_seen");
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("a_init_pulses", 512'(init_cnt), 512'(1));

    // both requesting continuously: strict alternation from index 0
    do_reset();
    eng_next_hash = H_B;
    push_exp(2'b01, 2'b00, 2'b01, H_B,          K0, M0);
    push_exp(2'b10, 2'b00, 2'b10, H_B + 256'd1, K1, M1);
    push_exp(2'b01, 2'b00, 2'b01, H_B + 256'd2, K0, M0);
    push_exp(2'b10, 2'b00, 2'b10, H_B + 256'd3, K1, M1);
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_resp("b_resp_seen");
    req = 2'b00;
    repeat (2) @(negedge clk);

    // inputs change and request drops one cycle after grant
    eng_next_hash = H_C;
    push_exp(2'b10, 2'b00, 2'b10, H_C, K1, M1);
    req = 2'b10;
    wait_gnt("c_gnt_seen");
    @(negedge clk);
    key = {K1N, K0};
    msg = {M1N, M0};
    req = 2'b00;
    wait_resp("c_resp_seen");
    repeat (2) @(negedge clk);
    chk("c_key_hold", 512'(ekey), 512'(K1));
    chk("c_msg_hold", emsg, M1);
    key = {K1, K0};
    msg = {M1, M0};

    // reset during WAIT_DONE, arbitration restarts from index 0
    do_reset();
    eng_next_hash = H_D;
    push_exp(2'b01, 2'b00, 2'b01, H_D, K0, M0);
    req = 2'b01;
    wait_resp("d_first_seen");
    req = 2'b00;
    repeat (2) @(negedge clk);
    req = 2'b11;
    wait_gnt("d_gnt_seen");
    chk("d_gnt_rr", 512'(gnt), 512'(2'b10));
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("d_async");
    // aborted operation consumes H_D+1 inside the engine model
    push_exp(2'b01, 2'b00, 2'b01, H_D + 256'd2, K0, M0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_resp("d_after_seen");
    req = 2'b00;
    repeat (2) @(negedge clk);

    // timeout path on the short-timeout instance
    push_to(2'b01, 2'b01, K0, M0);
    push_to(2'b10, 2'b10, K1, M1);
    req_to = 2'b11;
    wait_to("e_err0_seen");
    wait_to("e_err1_seen");
    req_to = 2'b00;

    repeat (5) @(negedge clk);
    chk("sb_empty",    512'(sb.size()),    512'(0));
    chk("sb_to_empty", 512'(sb_to.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
